// File: rtl/address_generator_pkg.sv
// address_generator_pkg: cfg word bit positions, byte shift and cfg field layout.
package address_generator_pkg;
    localparam int CFG_EN_BIT           = 0;
    localparam int CFG_VALID_BIT        = 1;
    localparam int CFG_SOFT_RESTART_BIT = 2;
    localparam int BYTE_SHIFT           = 2;

    typedef struct packed {
        logic [28:0] rsvd;
        logic        soft_restart;
        logic        valid_en;
        logic        en;
    } cfg_t;
endpackage

// File: rtl/addr_gen_counter.sv
// addr_gen_counter: word counter 0..per_q with wrap-time period latch.
// ADDR_GEN_SOFT_RESTART_EN adds a cfg[2] rising-edge restart.
module addr_gen_counter
    import address_generator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             soft_restart,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] per_q;
    logic             sr;

`ifdef ADDR_GEN_SOFT_RESTART_EN
    logic sr_q;
    always_ff @(posedge clk) begin
        if (!resetn) sr_q <= 1'b0;
        else         sr_q <= soft_restart;
    end
    assign sr = en && soft_restart && !sr_q;
`else
    logic unused_soft_restart;
    assign unused_soft_restart = soft_restart;
    assign sr = 1'b0;
`endif

    // Period is only re-latched while idle or at a wrap, so a running sequence is never cut short.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt   <= '0;
            per_q <= '0;
        end else if (!en || sr || cnt == per_q) begin
            cnt   <= '0;
            per_q <= period;
        end else begin
            cnt   <= cnt + WIDTH'(1);
        end
    end
endmodule

// File: rtl/address_generator.sv
// address_generator: free-running BRAM byte-address generator with restart pulse and valid flag.
// Optional soft restart on cfg[2] when ADDR_GEN_SOFT_RESTART_EN is defined.
module address_generator
    import address_generator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      cfg,
    input  logic [31:0]      period,
    output logic             restart,
    output logic [WIDTH+1:0] addr,
    output logic             tvalid
);
    logic [WIDTH-1:0] cnt;
    logic             en;
    logic             unused_bits;

    assign en          = cfg[CFG_EN_BIT];
    assign unused_bits = ^{cfg[31:3], period[31:WIDTH]};

    addr_gen_counter #(.WIDTH(WIDTH)) u_counter (
        .clk          (clk),
        .resetn       (resetn),
        .en           (en),
        .soft_restart (cfg[CFG_SOFT_RESTART_BIT]),
        .period       (period[WIDTH-1:0]),
        .cnt          (cnt)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr    <= '0;
            restart <= 1'b0;
            tvalid  <= 1'b0;
        end else begin
            addr    <= en ? (WIDTH+2)'(cnt) << BYTE_SHIFT : '0;
            restart <= en && cnt == '0;
            tvalid  <= en && cfg[CFG_VALID_BIT];
        end
    end
endmodule

// File: tb/tb_address_generator.sv
// tb_address_generator: per-cycle vector table with expected outputs fed through a scoreboard queue.
module tb_address_generator;
  localparam int WIDTH = 8;
  localparam int AW = WIDTH + 2;
  logic clk = 1'b0;
  logic resetn;
  logic [31:0] cfg;
  logic [31:0] period;
  logic restart;
  logic [AW-1:0] addr;
  logic tvalid;
  typedef struct {
    logic rn;
    logic [31:0] cfg;
    logic [31:0] period;
    logic [AW-1:0] addr;
    logic restart;
    logic tvalid;
  } vec_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic restart;
    logic tvalid;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  int passed = 0;
  int total = 0;
  logic done = 1'b0;
  always #4 clk = ~clk;
  address_generator #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .resetn(resetn),
    .cfg(cfg),
    .period(period),
    .restart(restart),
    .addr(addr),
    .tvalid(tvalid)
  );
  function automatic void add(logic rn, logic [31:0] c, logic [31:0] p, int a, logic r, logic v);
    vecs.push_back('{rn, c, p, AW'(a), r, v});
  endfunction
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL: timeout waiting for vector sequence to finish");
      $display("%0d/%0d checks passed", passed, total + 1);
      $finish;
    end
  end
  initial begin
    exp_t e;
    int a;
    resetn = 1'b0;
    cfg = '0;
    period = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (addr === '0 && restart === 1'b0 && tvalid === 1'b0) passed++;
      else $display("FAIL reset cycle %0d: addr=%0d restart=%b tvalid=%b", i, addr, restart, tvalid);
    end
    for (int i = 0; i < 3; i++) add(0, 0, 255, 0, 0, 0);
    for (int i = 0; i < 2; i++) add(1, 0, 255, 0, 0, 0);
    for (int j = 0; j < 553; j++) begin
      a = (j < 512) ? j % 256 : (j - 512) % 16;
      add(1, (j < 260) ? 32'h1 : 32'h3, (j < 300) ? 32'd255 : 32'd15, 4 * a, a == 0, j >= 260);
    end
    add(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 3, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 15, 0, 0, 0);
    for (int j = 0; j < 6; j++) add(1, 3, 15, 4 * j, j == 0, 1);
    add(1, 0, 3, 0, 0, 0);
    for (int j = 0; j < 6; j++) add(1, 32'hFFFF_FFF9, 32'hFFFF_FF03, 4 * (j % 4), (j % 4) == 0, 0);
    add(1, 0, 255, 0, 0, 0);
    for (int j = 0; j <= 100; j++) add(1, 3, 255, 4 * j, j == 0, 1);
    add(1, 7, 255, 404, 0, 1);
    for (int k = 0; k < 4; k++) begin
`ifdef ADDR_GEN_SOFT_RESTART_EN
      add(1, 7, 255, 4 * k, k == 0, 1);
`else
      add(1, 7, 255, 408 + 4 * k, 0, 1);
`endif
    end
    foreach (vecs[i]) begin
      @(negedge clk);
      resetn = vecs[i].rn;
      cfg = vecs[i].cfg;
      period = vecs[i].period;
      sb.push_back('{vecs[i].addr, vecs[i].restart, vecs[i].tvalid});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (addr === e.addr && restart === e.restart && tvalid === e.tvalid) passed++;
      else $display("FAIL vec %0d: got addr=%0d restart=%b tvalid=%b, want addr=%0d restart=%b tvalid=%b",
                    i, addr, restart, tvalid, e.addr, e.restart, e.tvalid);
    end
    done = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
